dentro_cerchio_param: RTL and testbench

- Parametrised successor of the fixed-radius inside-circle block.
- Drives two ADC-style producers for X and Y through soc/eoc handshakes and captures signed W-bit coordinates.
- Tests x²+y² <= r² against a runtime radius, using one iterative shift-add squarer.
- Hands z, an on-edge flag, the quadrant and a saturating inside-count to a consumer over a dav_/rfd handshake.

---
 rtl/dentro_cerchio_param_if.sv | 29 ++
 rtl/dentro_cerchio_param.sv | 138 +++++++++++++
 tb/tb_dentro_cerchio_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dentro_cerchio_param_if.sv
// Producer/consumer bundle of the inside-circle block: X/Y soc/eoc channels, radius, dav_/rfd result port.
interface dentro_cerchio_param_if #(
    parameter int W  = 8,
    parameter int CW = 16
);
    logic                 soc_x;
    logic                 eoc_x;
    logic signed [W-1:0]  x;
    logic                 soc_y;
    logic                 eoc_y;
    logic signed [W-1:0]  y;
    logic        [W-1:0]  r;
    logic                 dav_;
    logic                 rfd;
    logic                 z;
    logic                 on_edge;
    logic        [1:0]    quad;
    logic        [CW-1:0] count;

    modport master (
        output soc_x, soc_y, dav_, z, on_edge, quad, count,
        input  eoc_x, x, eoc_y, y, r, rfd
    );

    modport slave (
        input  soc_x, soc_y, dav_, z, on_edge, quad, count,
        output eoc_x, x, eoc_y, y, r, rfd
    );
endinterface

// File: rtl/dentro_cerchio_param.sv
// Inside-circle test of ADC-sampled (x,y) against a runtime radius using one shift-add squarer.
// Latency 3W+2 clocks from last capture to dav_=0; result held until the consumer drops rfd.
module dentro_cerchio_param #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic                   clock,
    input  logic                   reset_,
    dentro_cerchio_param_if.master bus
);
    typedef enum logic [2:0] {S_START, S_CONV, S_CALC, S_OUT, S_WAIT} state_t;

    localparam int             BW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0]  BIT_LAST = BW'(W - 1);
    localparam logic [BW-1:0]  BIT_ONE  = BW'(1);
    localparam logic [W-1:0]   ONE_W    = W'(1);
    localparam logic [CW-1:0]  ONE_C    = CW'(1);

    state_t               state, state_nxt;
    logic signed [W-1:0]  x_reg, y_reg;
    logic        [W-1:0]  r_reg;
    logic                 x_done, y_done;
    logic      [2*W-1:0]  mcand, sum_acc, rsq_acc;
    logic        [W-1:0]  mplier;
    logic       [BW-1:0]  bit_idx;
    logic        [1:0]    op_sel;

    // Magnitude stays W-bit unsigned, so the most negative sample maps to 2^(W-1) exactly.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + ONE_W) : v;
    endfunction

    assign bus.dav_ = (state != S_OUT);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) state <= S_START;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_START: if (bus.eoc_x && bus.eoc_y) state_nxt = S_CONV;
            S_CONV:  if (x_done && y_done)       state_nxt = S_CALC;
            S_CALC:  if (op_sel == 2'd3)         state_nxt = S_OUT;
            S_OUT:   if (!bus.rfd)               state_nxt = S_WAIT;
            S_WAIT:  if (bus.rfd)                state_nxt = S_START;
            default:                             state_nxt = S_START;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            bus.soc_x   <= 1'b0;
            bus.soc_y   <= 1'b0;
            bus.z       <= 1'b0;
            bus.on_edge <= 1'b0;
            bus.quad    <= 2'd0;
            bus.count   <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            r_reg       <= '0;
            x_done      <= 1'b0;
            y_done      <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            sum_acc     <= '0;
            rsq_acc     <= '0;
            bit_idx     <= '0;
            op_sel      <= 2'd0;
        end else begin
            case (state)
                S_START: begin
                    if (bus.eoc_x && bus.eoc_y) begin
                        bus.soc_x <= 1'b1;
                        bus.soc_y <= 1'b1;
                        r_reg     <= bus.r;
                        x_done    <= 1'b0;
                        y_done    <= 1'b0;
                    end
                end
                S_CONV: begin
                    // Each channel: drop soc once busy is seen, then capture on the return to idle.
                    if (bus.soc_x) begin
                        if (!bus.eoc_x) bus.soc_x <= 1'b0;
                    end else if (!x_done && bus.eoc_x) begin
                        x_reg  <= bus.x;
                        x_done <= 1'b1;
                    end
                    if (bus.soc_y) begin
                        if (!bus.eoc_y) bus.soc_y <= 1'b0;
                    end else if (!y_done && bus.eoc_y) begin
                        y_reg  <= bus.y;
                        y_done <= 1'b1;
                    end
                    if (x_done && y_done) begin
                        mcand   <= {{W{1'b0}}, mag(x_reg)};
                        mplier  <= mag(x_reg);
                        sum_acc <= '0;
                        rsq_acc <= '0;
                        bit_idx <= '0;
                        op_sel  <= 2'd0;
                    end
                end
                S_CALC: begin
                    if (op_sel != 2'd3) begin
                        // Operands in order |x|, |y| (into sum_acc), then r_reg (into rsq_acc).
                        if (mplier[0]) begin
                            if (op_sel == 2'd2) rsq_acc <= rsq_acc + mcand;
                            else                sum_acc <= sum_acc + mcand;
                        end
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        bit_idx <= bit_idx + BIT_ONE;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            op_sel  <= op_sel + 2'd1;
                            if (op_sel == 2'd0) begin
                                mcand  <= {{W{1'b0}}, mag(y_reg)};
                                mplier <= mag(y_reg);
                            end else begin
                                mcand  <= {{W{1'b0}}, r_reg};
                                mplier <= r_reg;
                            end
                        end
                    end else begin
                        bus.z       <= (sum_acc <= rsq_acc);
                        bus.on_edge <= (sum_acc == rsq_acc);
                        bus.quad    <= {y_reg[W-1], x_reg[W-1]};
                        if ((sum_acc <= rsq_acc) && (bus.count != '1))
                            bus.count <= bus.count + ONE_C;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dentro_cerchio_param.sv
// Directed bench: scripted X/Y producers feed points, a consumer/monitor pops expected results from a scoreboard.
module tb_dentro_cerchio_param;
    localparam int W   = 8;
    localparam int CW  = 2;
    localparam int LAT = 3 * W + 2;

    typedef struct packed {
        logic          z;
        logic          e;
        logic [1:0]    q;
        logic [CW-1:0] c;
    } exp_t;

    logic clock  = 1'b0;
    logic reset_ = 1'b0;
    always #5 clock = ~clock;

    dentro_cerchio_param_if #(.W(W), .CW(CW)) bus();
    dentro_cerchio_param #(.W(W), .CW(CW)) dut (.clock(clock), .reset_(reset_), .bus(bus));

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   cap_x     = 0;
    int   cap_y     = 0;
    int   n_seen    = 0;
    int   rfd_delay = 0;
    int   exp_count = 0;
    logic sx_prev   = 1'b0;
    logic sy_prev   = 1'b0;
    logic ex_prev   = 1'b0;
    logic ey_prev   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // A soc may only fall on an edge where its own eoc was already low.
    always @(negedge clock) begin
        if (reset_ && sx_prev && !bus.soc_x) chk("soc_x_fall_after_eoc", 32'(ex_prev), 0);
        if (reset_ && sy_prev && !bus.soc_y) chk("soc_y_fall_after_eoc", 32'(ey_prev), 0);
        sx_prev <= bus.soc_x;
        sy_prev <= bus.soc_y;
        ex_prev <= bus.eoc_x;
        ey_prev <= bus.eoc_y;
    end

    function automatic logic soc_of(input bit ch);
        return ch ? bus.soc_y : bus.soc_x;
    endfunction

    task automatic prod(input bit ch, input logic [W-1:0] v, input int d);
        int n;
        n = 0;
        while (soc_of(ch) !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
        if (n >= 100) chk(ch ? "soc_y_rise_timeout" : "soc_x_rise_timeout", 0, 1);
        repeat (d - 1) begin @(posedge clock); #1; end
        if (ch) bus.eoc_y = 1'b0; else bus.eoc_x = 1'b0;
        n = 0;
        while (soc_of(ch) !== 1'b0 && n < 100) begin @(posedge clock); #1; n++; end
        if (n >= 100) chk(ch ? "soc_y_fall_timeout" : "soc_x_fall_timeout", 0, 1);
        repeat (d - 1) begin @(posedge clock); #1; end
        if (ch) begin bus.y = v; bus.eoc_y = 1'b1; end
        else    begin bus.x = v; bus.eoc_x = 1'b1; end
        @(posedge clock); #1;
        // Capture edge has passed: scramble the sample and go busy so late changes must be ignored.
        if (ch) begin cap_y = cyc; bus.y = ~v; bus.eoc_y = 1'b0; end
        else    begin cap_x = cyc; bus.x = ~v; bus.eoc_x = 1'b0; end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_soc_x"},   32'(bus.soc_x),   0);
        chk({tag, "_soc_y"},   32'(bus.soc_y),   0);
        chk({tag, "_dav_"},    32'(bus.dav_),    1);
        chk({tag, "_z"},       32'(bus.z),       0);
        chk({tag, "_on_edge"}, 32'(bus.on_edge), 0);
        chk({tag, "_quad"},    32'(bus.quad),    0);
        chk({tag, "_count"},   32'(bus.count),   0);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clock);
        reset_ = 1'b0;
        #1;
        check_reset(tag);
        exp_count = 0;
        sb.delete();
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
    endtask

    // mode 0: full transaction; mode 1: reset while squaring; mode 2: reset while presenting.
    task automatic run_point(input int mode, input logic [W-1:0] xv, input logic [W-1:0] yv,
                             input logic [W-1:0] rv, input logic [W-1:0] r2, input int dx, input int dy,
                             input logic ez, input logic ee, input logic [1:0] eq, input int dly);
        exp_t e;
        int   n;
        int   target;
        target    = n_seen + 1;
        bus.r     = rv;
        rfd_delay = dly;
        if (mode != 1) begin
            if (ez && exp_count < (1 << CW) - 1) exp_count++;
            e.z = ez; e.e = ee; e.q = eq; e.c = CW'(exp_count);
            sb.push_back(e);
        end
        @(posedge clock); #1;
        bus.eoc_x = 1'b1;
        bus.eoc_y = 1'b1;
        @(posedge clock); #1;
        bus.r = r2;
        fork
            prod(1'b0, xv, dx);
            prod(1'b1, yv, dy);
        join
        if (mode == 1) begin
            repeat (5) @(posedge clock);
            reset_pulse("rst_calc");
        end else if (mode == 2) begin
            n = 0;
            while (bus.dav_ !== 1'b0 && n < 100) begin @(posedge clock); #1; n++; end
            if (n >= 100) chk("dav_fall_timeout", 0, 1);
            repeat (4) @(posedge clock);
            reset_pulse("rst_out");
        end else begin
            n = 0;
            while (n_seen != target && n < 300) begin @(posedge clock); #1; n++; end
            if (n >= 300) chk("result_timeout", 0, 1);
        end
    endtask

    // Consumer and monitor: compare on dav_ fall, hold rfd high rfd_delay clocks checking stability.
    initial begin : consumer
        exp_t e;
        bit   aborted;
        int   n;
        forever begin
            @(posedge clock); #1;
            if (reset_ && bus.dav_ === 1'b0) begin
                chk("latency", 32'(cyc - ((cap_x > cap_y) ? cap_x : cap_y)), LAT);
                if (sb.size() == 0) begin
                    chk("unexpected_result", 0, 1);
                    e = '0;
                end else begin
                    e = sb.pop_front();
                end
                chk("z",       32'(bus.z),       32'(e.z));
                chk("on_edge", 32'(bus.on_edge), 32'(e.e));
                chk("quad",    32'(bus.quad),    32'(e.q));
                chk("count",   32'(bus.count),   32'(e.c));
                aborted = 1'b0;
                for (int i = 0; i < rfd_delay; i++) begin
                    @(posedge clock); #1;
                    if (!reset_) begin aborted = 1'b1; break; end
                    chk("hold_while_rfd", 32'({bus.dav_, bus.z, bus.on_edge, bus.quad, bus.count}),
                        32'({1'b0, e.z, e.e, e.q, e.c}));
                end
                if (!aborted) begin
                    bus.rfd = 1'b0;
                    n = 0;
                    while (bus.dav_ !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
                    if (n >= 20) chk("dav_rise_timeout", 0, 1);
                    @(posedge clock); #1;
                    bus.rfd = 1'b1;
                    n_seen++;
                end
            end
        end
    end

    initial begin : stimulus
        bus.eoc_x = 1'b0;
        bus.eoc_y = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        bus.r     = '0;
        bus.rfd   = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset("reset");
        @(negedge clock);
        reset_ = 1'b1;

        //        mode  x           y           r      r_late dx dy  z     e     q      rfd_dly
        run_point(0,    8'd0,       8'd0,       8'd64,  8'd64,  1, 2, 1'b1, 1'b0, 2'd0, 0);
        run_point(0,    8'd64,      8'd0,       8'd64,  8'd64,  2, 1, 1'b1, 1'b1, 2'd0, 10);
        run_point(0,   -8'sd40,    -8'sd40,     8'd64,  8'd64,  1, 1, 1'b1, 1'b0, 2'd3, 0);
        run_point(0,    8'h80,      8'h80,      8'd255, 8'd255, 1, 2, 1'b1, 1'b0, 2'd3, 0);
        run_point(0,    8'h80,      8'd0,       8'd128, 8'd128, 2, 1, 1'b1, 1'b1, 2'd1, 3);
        run_point(0,    8'd50,      8'd40,      8'd64,  8'd64,  1, 1, 1'b0, 1'b0, 2'd0, 0);
        run_point(0,    8'h80,      8'd0,       8'd64,  8'd64,  1, 1, 1'b0, 1'b0, 2'd1, 0);
        run_point(0,    8'd0,       8'd0,       8'd0,   8'd0,   1, 1, 1'b1, 1'b1, 2'd0, 0);
        run_point(0,    8'd40,      8'd40,      8'd64,  8'd10,  1, 2, 1'b1, 1'b0, 2'd0, 0);
        run_point(1,    8'd10,      8'd20,      8'd64,  8'd64,  1, 1, 1'b1, 1'b0, 2'd0, 0);
        run_point(2,   -8'sd5,      8'd7,       8'd64,  8'd64,  1, 1, 1'b1, 1'b0, 2'd1, 30);
        run_point(0,    8'd30,      8'd50,      8'd64,  8'd64,  1, 1, 1'b1, 1'b0, 2'd0, 0);
        run_point(0,    8'd3,      -8'sd4,      8'd5,   8'd5,   2, 2, 1'b1, 1'b1, 2'd2, 0);
        run_point(0,   -8'sd100,    8'd100,     8'd100, 8'd100, 1, 1, 1'b0, 1'b0, 2'd1, 0);

        repeat (5) @(posedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
